// File: rtl/disp_scan_ctrl.sv
// Formats a binary value into hex or decimal digit codes, then time-multiplexes them onto one shared decoder.
// Hex commits 1 cycle after load and decimal DATA_W+1 cycles after; loads while busy are dropped; the scanner never stalls.
module disp_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
    input  logic                  dec_mode,
    input  logic                  blank_en,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            code,
    output logic [NUM_DIGITS-1:0] digit_en
);
    // Decimal digits needed for 2^DATA_W-1 (floor(DATA_W*log10(2))+1)
    localparam int BCD_REQ = (DATA_W * 301) / 1000 + 1;
    localparam int BCD_N   = (BCD_REQ > NUM_DIGITS) ? BCD_REQ : NUM_DIGITS;
    localparam int BCD_W   = 4 * BCD_N;
    localparam int HEX_W   = DATA_W + 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(DATA_W);
    localparam int PRE_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [4:0] C_H     = 5'd16;
    localparam logic [4:0] C_BLANK = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;
    state_t r_state, w_state_nxt;

    logic [DATA_W-1:0] r_shift;
    logic [BCD_W-1:0]  r_bcd, w_bcd_adj, w_bcd_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_blank;
    logic [4:0]        r_dig [NUM_DIGITS];
    logic              w_conv_last, w_commit;

    logic [HEX_W-1:0]  w_hex_pad;
    logic [4:0]        w_raw [NUM_DIGITS];
    logic [4:0]        w_fmt [NUM_DIGITS];
    logic              w_ovf, w_blank_sel, w_nz_seen;

    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic                  w_wrap;
    logic [4:0]            r_code;
    logic [NUM_DIGITS-1:0] r_digit_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (load) w_state_nxt = dec_mode ? S_CONVERT : S_COMMIT;
            S_CONVERT: if (w_conv_last) w_state_nxt = S_COMMIT;
            S_COMMIT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_CONVERT: busy = 1'b1;
            S_COMMIT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_conv_last = (r_state == S_CONVERT) && (r_cnt == CNT_W'(DATA_W - 1));
    // Digits land on the edge that enters COMMIT, so done and the new display appear together
    assign w_commit    = ((r_state == S_IDLE) && load && !dec_mode) || w_conv_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_blank <= 1'b0;
        end else if ((r_state == S_IDLE) && load) begin
            r_shift <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_blank <= blank_en;
        end else if (r_state == S_CONVERT) begin
            r_shift <= r_shift << 1;
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < BCD_N; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    assign w_bcd_nxt = (w_bcd_adj << 1) | BCD_W'(r_shift[DATA_W-1]);
    assign w_hex_pad = {{(4*NUM_DIGITS){1'b0}}, value};

    always_comb begin
        w_ovf       = 1'b0;
        w_blank_sel = 1'b0;
        w_nz_seen   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_raw[k] = 5'd0;
            w_fmt[k] = 5'd0;
        end
        if (r_state == S_CONVERT) begin
            w_ovf       = |(w_bcd_nxt >> (4 * NUM_DIGITS));
            w_blank_sel = r_blank;
            for (int k = 0; k < NUM_DIGITS; k++) w_raw[k] = {1'b0, w_bcd_nxt[4*k +: 4]};
        end else begin
            w_ovf       = |(w_hex_pad >> (4 * NUM_DIGITS));
            w_blank_sel = blank_en;
            for (int k = 0; k < NUM_DIGITS; k++) w_raw[k] = {1'b0, w_hex_pad[4*k +: 4]};
        end
        // Walk from the top digit down; blanking stops at the first nonzero digit
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (w_ovf)
                w_fmt[k] = C_H;
            else if (w_blank_sel && !w_nz_seen && (k != 0) && (w_raw[k] == 5'd0))
                w_fmt[k] = C_BLANK;
            else
                w_fmt[k] = w_raw[k];
            if (w_raw[k] != 5'd0) w_nz_seen = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) r_dig[k] <= C_BLANK;
        end else if (w_commit) begin
            for (int k = 0; k < NUM_DIGITS; k++) r_dig[k] <= w_fmt[k];
        end
    end

    assign w_wrap = (r_pre == PRE_W'(REFRESH_DIV - 1));

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_wrap) w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end

    // code and enable are both loaded from the next index so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre      <= '0;
            r_idx      <= '0;
            r_code     <= C_BLANK;
            r_digit_en <= ~NUM_DIGITS'(1);
        end else begin
            r_pre      <= w_wrap ? '0 : r_pre + 1'b1;
            r_idx      <= w_idx_nxt;
            r_code     <= r_dig[w_idx_nxt];
            r_digit_en <= ~(NUM_DIGITS'(1) << w_idx_nxt);
        end
    end

    assign code     = r_code;
    assign digit_en = r_digit_en;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized scoreboard bench: two instances (DATA_W 16 and 20) share stimulus; display content is checked through the scan outputs.
module tb_disp_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;

    typedef struct packed {
        logic [ND-1:0][4:0] dig;
        int                 done_k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        dec_mode = 1'b0;
    logic        blank_en = 1'b0;
    logic [19:0] value = '0;
    logic        busy [2];
    logic        done [2];
    logic [4:0]  code [2];
    logic [ND-1:0] den [2];

    int k;
    exp_t q [2][$];
    int last_done [2];
    logic [ND-1:0][4:0] disp [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(16), .REFRESH_DIV(RD)) dut16 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value[15:0]),
        .dec_mode(dec_mode), .blank_en(blank_en), .busy(busy[0]), .done(done[0]),
        .code(code[0]), .digit_en(den[0])
    );

    disp_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(20), .REFRESH_DIV(RD)) dut20 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .dec_mode(dec_mode), .blank_en(blank_en), .busy(busy[1]), .done(done[1]),
        .code(code[1]), .digit_en(den[1])
    );

    // Clock edges elapsed since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d k=%0d actual=%0d required=%0d", name, d, k, act, req);
        end
    endtask

    // Display contents straight from the arithmetic definition of each digit
    function automatic logic [ND-1:0][4:0] model(input logic [19:0] v, input bit dec, input bit blk);
        int unsigned base, n, p, lim;
        logic [ND-1:0][4:0] r;
        base = dec ? 10 : 16;
        n    = v;
        lim  = 1;
        repeat (ND) lim = lim * base;
        if (n >= lim) begin
            for (int j = 0; j < ND; j++) r[j] = 5'd16;
        end else begin
            p = 1;
            for (int j = 0; j < ND; j++) begin
                r[j] = 5'((n / p) % base);
                if (blk && j > 0 && n < p) r[j] = 5'd17;
                p = p * base;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        int idx;
        bit eb, ed;
        logic [ND-1:0] en_exp;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                q[d].delete();
                for (int j = 0; j < ND; j++) disp[d][j] = 5'd17;
                chk("rst_busy", d, 32'(busy[d]), 0);
                chk("rst_done", d, 32'(done[d]), 0);
                chk("rst_code", d, 32'(code[d]), 17);
                chk("rst_digit_en", d, 32'(den[d]), 32'b1110);
            end else begin
                idx    = (k / RD) % ND;
                en_exp = ~(ND'(1) << idx);
                eb     = (q[d].size() > 0) && (k <= q[d][0].done_k);
                ed     = (q[d].size() > 0) && (k == q[d][0].done_k);
                chk("digit_en", d, 32'(den[d]), 32'(en_exp));
                chk("code", d, 32'(code[d]), 32'(disp[d][idx]));
                chk("busy", d, 32'(busy[d]), 32'(eb));
                chk("done", d, 32'(done[d]), 32'(ed));
                if (ed) begin
                    disp[d] = q[d][0].dig;
                    void'(q[d].pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic issue(input logic [19:0] v, input bit dec, input bit blk);
        int kk;
        exp_t e;
        kk       = k + 1;
        value    = v;
        dec_mode = dec;
        blank_en = blk;
        load     = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (kk >= last_done[d] + 2) begin
                e.dig        = model((d == 0) ? (v & 20'hFFFF) : v, dec, blk);
                e.done_k     = kk + (dec ? ((d == 0) ? 16 : 20) : 0);
                last_done[d] = e.done_k;
                q[d].push_back(e);
            end
        end
        idle(1);
        load     = 1'b0;
        dec_mode = 1'($urandom);
        blank_en = 1'($urandom);
        value    = 20'($urandom);
    endtask

    task automatic do_reset(input int n);
        rst_n        = 1'b0;
        load         = 1'b0;
        last_done[0] = -10;
        last_done[1] = -10;
        idle(n);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [19:0] v;
        last_done[0] = -10;
        last_done[1] = -10;
        for (int d = 0; d < 2; d++)
            for (int j = 0; j < ND; j++) disp[d][j] = 5'd17;
        #3;
        idle(3);
        rst_n = 1'b1;
        idle(40);

        issue(20'h003AF, 1'b0, 1'b1);  idle(20);
        issue(20'h003AF, 1'b0, 1'b0);  idle(20);
        issue(20'd1234, 1'b1, 1'b1);   idle(25);
        issue(20'd0, 1'b1, 1'b1);      idle(25);
        issue(20'd10000, 1'b1, 1'b0);  idle(25);
        issue(20'h10000, 1'b0, 1'b1);  idle(20);

        // Collisions at 3 and 17 cycles after a decimal load
        issue(20'd4321, 1'b1, 1'b1);
        idle(2);
        issue(20'd9999, 1'b1, 1'b0);
        idle(13);
        issue(20'd5555, 1'b0, 1'b0);
        idle(30);

        // Abort in the middle of a conversion, then convert again
        issue(20'd4321, 1'b1, 1'b0);
        idle(7);
        do_reset(2);
        idle(5);
        issue(20'd1234, 1'b1, 1'b0);
        idle(30);

        repeat (60) begin
            case ($urandom_range(0, 3))
                0:       v = 20'($urandom_range(0, 15));
                1:       v = 20'($urandom_range(0, 9999));
                2:       v = 20'($urandom_range(0, 99999));
                default: v = 20'($urandom);
            endcase
            issue(v, 1'($urandom), 1'($urandom));
            idle($urandom_range(0, 24));
        end
        idle(30);

        for (int d = 0; d < 2; d++) chk("pending_done", d, 32'(q[d].size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
